// File: rtl/clk_switch_pkg.sv
// Shared types and constants for the two-source clock switch sequencer.
package clk_switch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/clk_switch_ctrl_sync_2ff.sv
// Two-flop synchronizer for the asynchronous clock-present flags.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequencer driving the glitch-free clock switch select: request handling,
// settle hold-off, dead-source rejection and automatic fallback.
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int FAIL_FILT  = 8,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw_req,
  input  logic sw_tgt,
  input  logic clka_ok,
  input  logic clkb_ok,
  output logic sel,
  output logic cur_src,
  output logic busy,
  output logic sw_ack,
  output logic sw_err,
  output logic fb_evt
);

  localparam logic [CNT_W-1:0] FILT_MAX    = CNT_W'(FAIL_FILT);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  function automatic logic [CNT_W-1:0] filt_next(input logic [CNT_W-1:0] cnt,
                                                 input logic ok);
    if (ok)                 return '0;
    else if (cnt == FILT_MAX) return cnt;
    else                    return cnt + CNT_ONE;
  endfunction

  logic a_ok_s, b_ok_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_a (
    .clk (clk),
    .rstn(rstn),
    .d_i (clka_ok),
    .q_o (a_ok_s)
  );

  sync_2ff #(.RST_VAL(1'b1)) u_sync_b (
    .clk (clk),
    .rstn(rstn),
    .d_i (clkb_ok),
    .q_o (b_ok_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] fcnt_a_q, fcnt_b_q;
  logic             sel_q, sel_d;
  logic             cur_q, cur_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             fbevt_q, fbevt_d;
  logic             fb_q, fb_d;

  logic a_fail, b_fail, cur_fail, oth_ok, tgt_ok;

  assign a_fail   = (fcnt_a_q == FILT_MAX);
  assign b_fail   = (fcnt_b_q == FILT_MAX);
  assign cur_fail = (cur_q == SRC_B) ? b_fail : a_fail;
  assign oth_ok   = (cur_q == SRC_B) ? a_ok_s : b_ok_s;
  assign tgt_ok   = (sw_tgt == SRC_B) ? b_ok_s : a_ok_s;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    sel_d    = sel_q;
    cur_d    = cur_q;
    fb_d     = fb_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    fbevt_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Fallback outranks any pending request; a dead pair never falls back.
        if (cur_fail && oth_ok) begin
          sel_d    = ~cur_q;
          fbevt_d  = 1'b1;
          fb_d     = 1'b1;
          settle_d = '0;
          state_d  = SETTLE;
        end else if (sw_req) begin
          if (sw_tgt == cur_q) begin
            ack_d = 1'b1;
          end else if (!tgt_ok) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else begin
            state_d = SWITCH;
          end
        end
      end
      SWITCH: begin
        sel_d    = sw_tgt;
        settle_d = '0;
        fb_d     = 1'b0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          cur_d   = sel_q;
          state_d = DONE;
        end else begin
          settle_d = settle_q + CNT_ONE;
        end
      end
      DONE: begin
        ack_d   = ~fb_q;
        fb_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      settle_q <= '0;
      fcnt_a_q <= '0;
      fcnt_b_q <= '0;
      sel_q    <= SRC_A;
      cur_q    <= SRC_A;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      fbevt_q  <= 1'b0;
      fb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      fcnt_a_q <= filt_next(fcnt_a_q, a_ok_s);
      fcnt_b_q <= filt_next(fcnt_b_q, b_ok_s);
      sel_q    <= sel_d;
      cur_q    <= cur_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      fbevt_q  <= fbevt_d;
      fb_q     <= fb_d;
    end
  end

  assign sel     = sel_q;
  assign cur_src = cur_q;
  assign busy    = busy_q;
  assign sw_ack  = ack_q;
  assign sw_err  = err_q;
  assign fb_evt  = fbevt_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed bench for clk_switch_ctrl with hand-computed cycle expectations.
module tb_clk_switch_ctrl;

  logic clk = 1'b0;
  logic rstn, sw_req, sw_tgt, clka_ok, clkb_ok;
  logic sel, cur_src, busy, sw_ack, sw_err, fb_evt;

  int errs   = 0;
  int checks = 0;

  clk_switch_ctrl #(.SETTLE_CYC(16), .FAIL_FILT(8), .CNT_W(5)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .sw_req (sw_req),
    .sw_tgt (sw_tgt),
    .clka_ok(clka_ok),
    .clkb_ok(clkb_ok),
    .sel    (sel),
    .cur_src(cur_src),
    .busy   (busy),
    .sw_ack (sw_ack),
    .sw_err (sw_err),
    .fb_evt (fb_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts cycles from request launch until sw_ack, bounded.
  task automatic wait_ack(input int start, output int lat, output int busy_drop);
    lat = start;
    busy_drop = 0;
    while (!sw_ack && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!sw_ack && !busy) busy_drop = 1;
    end
  endtask

  initial begin
    int lat, bdrop, fb_n, cur_n, fb_cnt, ack_seen, sel_bad;
    rstn = 1'b0; sw_req = 1'b0; sw_tgt = 1'b0; clka_ok = 1'b1; clkb_ok = 1'b1;
    wait_neg(3);
    chk("rst_sel", sel, 0);
    chk("rst_cur", cur_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", sw_ack, 0);
    chk("rst_err", sw_err, 0);
    chk("rst_fb", fb_evt, 0);
    rstn = 1'b1;
    wait_neg(2);

    // Reject switch to a dead source
    clkb_ok = 1'b0;
    wait_neg(20);
    sw_req = 1'b1; sw_tgt = 1'b1;
    wait_neg(1);
    chk("rej_ack", sw_ack, 1);
    chk("rej_err", sw_err, 1);
    chk("rej_sel", sel, 0);
    chk("rej_busy", busy, 0);
    sw_req = 1'b0;
    clkb_ok = 1'b1;
    wait_neg(5);

    // Accepted switch A -> B
    sw_req = 1'b1; sw_tgt = 1'b1;
    wait_neg(1);
    chk("sw_busy1", busy, 1);
    chk("sw_sel1", sel, 0);
    wait_neg(1);
    chk("sw_sel2", sel, 1);
    wait_ack(2, lat, bdrop);
    chk("sw_lat", lat, 19);
    chk("sw_busy_hold", bdrop, 0);
    chk("sw_cur", cur_src, 1);
    chk("sw_err", sw_err, 0);
    sw_req = 1'b0;
    wait_neg(1);
    chk("sw_ack_once", sw_ack, 0);
    chk("sw_idle", busy, 0);

    // Request to the already-active source
    sw_req = 1'b1; sw_tgt = 1'b1;
    wait_neg(1);
    chk("same_ack", sw_ack, 1);
    chk("same_err", sw_err, 0);
    chk("same_sel", sel, 1);
    chk("same_busy", busy, 0);
    sw_req = 1'b0;
    wait_neg(1);
    chk("same_ack_once", sw_ack, 0);

    // Active source B fails for 12 cycles -> fallback to A
    clkb_ok = 1'b0;
    fb_n = 0; cur_n = 0; fb_cnt = 0; ack_seen = 0; sel_bad = 0;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (n == 12) clkb_ok = 1'b1;
      if (fb_evt) begin
        fb_cnt++;
        if (fb_n == 0) fb_n = n;
      end
      if (cur_src == 1'b0 && cur_n == 0) cur_n = n;
      if (sw_ack) ack_seen = 1;
      if (n >= 11 && sel != 1'b0) sel_bad = 1;
    end
    chk("fb_time", fb_n, 11);
    chk("fb_pulses", fb_cnt, 1);
    chk("fb_sel_hold", sel_bad, 0);
    chk("fb_cur_time", cur_n, 27);
    chk("fb_no_ack", ack_seen, 0);
    chk("fb_idle", busy, 0);

    // Short glitch on active A (7 cycles) must not trigger fallback
    clka_ok = 1'b0;
    wait_neg(7);
    clka_ok = 1'b1;
    fb_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fb_evt || sel) fb_cnt++;
    end
    chk("glitch_nofb", fb_cnt, 0);

    // Both sources dead: no fallback, requests rejected
    clka_ok = 1'b0; clkb_ok = 1'b0;
    fb_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fb_evt || sel || busy) fb_cnt++;
    end
    chk("both_nofb", fb_cnt, 0);
    sw_req = 1'b1; sw_tgt = 1'b1;
    wait_neg(1);
    chk("both_ack", sw_ack, 1);
    chk("both_err", sw_err, 1);
    sw_req = 1'b0;
    clka_ok = 1'b1;
    wait_neg(5);
    clkb_ok = 1'b1;
    wait_neg(5);
    chk("both_sel", sel, 0);
    chk("both_cur", cur_src, 0);

    // Async reset in the middle of SETTLE, request kept pending
    sw_req = 1'b1; sw_tgt = 1'b1;
    wait_neg(8);
    chk("mid_sel", sel, 1);
    chk("mid_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("ar_sel", sel, 0);
    chk("ar_cur", cur_src, 0);
    chk("ar_busy", busy, 0);
    wait_neg(2);
    chk("ar_noack", sw_ack, 0);
    rstn = 1'b1;
    wait_ack(0, lat, bdrop);
    chk("ar_lat", lat, 19);
    chk("ar_cur_after", cur_src, 1);
    chk("ar_sel_after", sel, 1);
    sw_req = 1'b0;
    wait_neg(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
